// File: rtl/wr_slave_arbiter.sv
// Three-master to one-slave write arbiter: round-robin AW grant, W ordering
// via a small FIFO of granted master indices, and B routing by the upper
// ID bits. Outstanding writes at the slave are capped at MAX_OUT.
module wr_slave_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // master AW
  input  logic [2:0]            m_awvalid,
  output logic [2:0]            m_awready,
  input  logic [11:0]           m_awid,
  input  logic [3*ADDR_W-1:0]   m_awaddr,
  input  logic [23:0]           m_awlen,
  // master W
  input  logic [2:0]            m_wvalid,
  input  logic [2:0]            m_wlast,
  output logic [2:0]            m_wready,
  input  logic [3*DATA_W-1:0]   m_wdata,
  // master B
  output logic [2:0]            m_bvalid,
  input  logic [2:0]            m_bready,
  output logic [3:0]            m_bid,
  output logic [1:0]            m_bresp,
  // slave AW
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [5:0]            s_awid,
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic [7:0]            s_awlen,
  // slave W
  output logic                  s_wvalid,
  output logic [DATA_W-1:0]     s_wdata,
  output logic                  s_wlast,
  input  logic                  s_wready,
  // slave B
  input  logic                  s_bvalid,
  input  logic [5:0]            s_bid,
  input  logic [1:0]            s_bresp,
  output logic                  s_bready,
  // status
  output logic [2:0]            out_cnt
);

  localparam logic [2:0] MAX_C    = 3'(MAX_OUT);
  localparam int         PTR_W    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic              aw_valid_q;
  logic [1:0]        grant_idx;
  logic [1:0]        last_grant;
  logic [1:0]        next_grant;

  logic [1:0]        fifo_mem [(1 << PTR_W)];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [2:0]        fifo_cnt;
  logic              fifo_empty;
  logic [1:0]        head;

  logic [3:0]        sel_awid;
  logic [ADDR_W-1:0] sel_awaddr;
  logic [7:0]        sel_awlen;
  logic              sel_wvalid;
  logic              sel_wlast;
  logic [DATA_W-1:0] sel_wdata;

  logic              aw_hs;
  logic              b_hs;
  logic              w_pop;
  logic [1:0]        b_idx;

  assign aw_hs      = aw_valid_q & s_awready;
  assign b_hs       = s_bvalid & s_bready;
  assign fifo_empty = (fifo_cnt == 3'd0);
  assign head       = fifo_mem[rd_ptr];
  assign b_idx      = s_bid[5:4];

  // Round-robin pick: first requester at or after last_grant+1 (mod 3)
  always_comb begin
    logic [1:0] start;
    logic [2:0] sum;
    logic [1:0] cand;
    logic       found;
    next_grant = 2'd0;
    found      = 1'b0;
    start      = (last_grant >= 2'd2) ? 2'd0 : last_grant + 2'd1;
    for (int unsigned i = 0; i < 3; i++) begin
      sum  = {1'b0, start} + 3'(i);
      cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!found && m_awvalid[cand]) begin
        found      = 1'b1;
        next_grant = cand;
      end
    end
  end

  // Payload muxes: AW fields from the granted master, W fields from FIFO head
  always_comb begin
    sel_awid   = '0;
    sel_awaddr = '0;
    sel_awlen  = '0;
    sel_wvalid = 1'b0;
    sel_wlast  = 1'b0;
    sel_wdata  = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (grant_idx == 2'(k)) begin
        sel_awid   = m_awid[k*4 +: 4];
        sel_awaddr = m_awaddr[k*ADDR_W +: ADDR_W];
        sel_awlen  = m_awlen[k*8 +: 8];
      end
      if (head == 2'(k)) begin
        sel_wvalid = m_wvalid[k];
        sel_wlast  = m_wlast[k];
        sel_wdata  = m_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign s_awvalid = aw_valid_q;
  assign s_awid    = {grant_idx, sel_awid};
  assign s_awaddr  = sel_awaddr;
  assign s_awlen   = sel_awlen;
  assign m_awready = aw_valid_q ? (3'(s_awready) << grant_idx) : '0;

  assign s_wvalid  = !fifo_empty && sel_wvalid;
  assign s_wdata   = sel_wdata;
  assign s_wlast   = sel_wlast;
  assign m_wready  = fifo_empty ? '0 : (3'(s_wready) << head);
  assign w_pop     = s_wvalid & s_wready & s_wlast;

  assign m_bid     = s_bid[3:0];
  assign m_bresp   = s_bresp;

  // B routing by ID prefix; prefix 3 has no owner and is sunk silently.
  // m_bvalid is held low while reset is asserted so no B completes then.
  always_comb begin
    m_bvalid = '0;
    s_bready = 1'b1;
    if (b_idx != 2'd3) begin
      s_bready = m_bready[b_idx];
      if (rst_n) m_bvalid[b_idx] = s_bvalid;
    end
  end

  // AW FSM: grant is captured on entry to GRANT and held until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      aw_valid_q <= 1'b0;
      grant_idx  <= 2'd0;
      last_grant <= 2'd2;
    end else begin
      case (state)
        IDLE: begin
          if (|m_awvalid && (out_cnt < MAX_C) && (fifo_cnt < MAX_C)) begin
            state      <= GRANT;
            aw_valid_q <= 1'b1;
            grant_idx  <= next_grant;
          end
        end
        GRANT: begin
          if (s_awready) begin
            state      <= IDLE;
            aw_valid_q <= 1'b0;
            last_grant <= grant_idx;
          end
        end
        default: begin
          state      <= IDLE;
          aw_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding counter: AW adds, B removes, both together cancel; floor at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (aw_hs && !b_hs) begin
      out_cnt <= out_cnt + 3'd1;
    end else if (b_hs && !aw_hs && (out_cnt != 3'd0)) begin
      out_cnt <= out_cnt - 3'd1;
    end
  end

  // W-order FIFO: push granted index on AW accept, pop on last W beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int unsigned i = 0; i < (1 << PTR_W); i++) fifo_mem[i] <= '0;
    end else begin
      if (aw_hs) begin
        fifo_mem[wr_ptr] <= grant_idx;
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (w_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({aw_hs, w_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_wr_slave_arbiter.sv
// Directed bench for wr_slave_arbiter: one task per scenario, inline checks.
module tb_wr_slave_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2:0]          m_awvalid, m_awready;
  logic [11:0]         m_awid;
  logic [3*ADDR_W-1:0] m_awaddr;
  logic [23:0]         m_awlen;
  logic [2:0]          m_wvalid, m_wlast, m_wready;
  logic [3*DATA_W-1:0] m_wdata;
  logic [2:0]          m_bvalid, m_bready;
  logic [3:0]          m_bid;
  logic [1:0]          m_bresp;
  logic                s_awvalid, s_awready;
  logic [5:0]          s_awid;
  logic [ADDR_W-1:0]   s_awaddr;
  logic [7:0]          s_awlen;
  logic                s_wvalid, s_wlast, s_wready;
  logic [DATA_W-1:0]   s_wdata;
  logic                s_bvalid, s_bready;
  logic [5:0]          s_bid;
  logic [1:0]          s_bresp;
  logic [2:0]          out_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wr_slave_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bresp(s_bresp), .s_bready(s_bready),
    .out_cnt(out_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_awvalid = '0; m_awid = '0; m_awaddr = '0; m_awlen = '0;
    m_wvalid = '0; m_wlast = '0; m_wdata = '0; m_bready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #2;
    checks++;
    if ({s_awvalid, s_wvalid, m_awready, m_wready, m_bvalid, out_cnt} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got aw=%b w=%b awr=%b wr=%b bv=%b cnt=%0d want all 0",
               s_awvalid, s_wvalid, m_awready, m_wready, m_bvalid, out_cnt);
    end
    checks++;
    if (s_bready !== 1'b0) begin
      errors++; $display("FAIL reset_bready_idx0: got %b want 0", s_bready);
    end
    s_bid = 6'h30; s_bvalid = 1'b1;
    #1;
    checks++;
    if ({s_bready, m_bvalid} !== 4'b1000) begin
      errors++; $display("FAIL reset_bready_idx3: got bready=%b bvalid=%b want 1/000", s_bready, m_bvalid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_round_robin();
    do_reset();
    m_awaddr = {32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
    m_awvalid = 3'b111; s_awready = 1'b1;
    m_wvalid = 3'b111; m_wlast = 3'b111; s_wready = 1'b1;
    s_bvalid = 1'b1; s_bid = 6'h30;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({s_awvalid, s_awid[5:4]} !== {1'b1, 2'(i % 3)}) begin
        errors++; $display("FAIL rr_grant%0d: got v=%b idx=%0d want v=1 idx=%0d", i, s_awvalid, s_awid[5:4], i % 3);
      end
      checks++;
      if (s_awaddr !== 32'h0000_00A0 + 32'(i % 3)) begin
        errors++; $display("FAIL rr_addr%0d: got %h want %h", i, s_awaddr, 32'h0000_00A0 + 32'(i % 3));
      end
      step();
      checks++;
      if (s_awvalid !== 1'b0) begin
        errors++; $display("FAIL rr_idle%0d: got s_awvalid=%b want 0", i, s_awvalid);
      end
    end
    checks++;
    if (out_cnt !== 3'd0) begin
      errors++; $display("FAIL rr_cnt: got %0d want 0", out_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_id_route();
    do_reset();
    m_awvalid = 3'b010; m_awid = 12'h0A0;
    m_awaddr = {32'h0, 32'hDEAD_0001, 32'h0}; m_awlen = 24'h00_05_00;
    s_awready = 1'b1;
    step();
    m_awvalid = 3'b000;
    checks++;
    if ({s_awvalid, s_awid, s_awaddr, s_awlen, m_awready} !== {1'b1, 6'h1A, 32'hDEAD_0001, 8'h05, 3'b010}) begin
      errors++; $display("FAIL id_aw: got v=%b id=%h addr=%h len=%h rdy=%b want 1/1a/dead0001/05/010",
                         s_awvalid, s_awid, s_awaddr, s_awlen, m_awready);
    end
    step();
    checks++;
    if (out_cnt !== 3'd1) begin
      errors++; $display("FAIL id_cnt1: got %0d want 1", out_cnt);
    end
    s_bvalid = 1'b1; s_bid = 6'h1A; s_bresp = 2'b10; m_bready = 3'b010;
    #1;
    checks++;
    if ({m_bvalid, m_bid, m_bresp, s_bready} !== {3'b010, 4'hA, 2'b10, 1'b1}) begin
      errors++; $display("FAIL id_b: got bv=%b bid=%h resp=%b bready=%b want 010/a/10/1",
                         m_bvalid, m_bid, m_bresp, s_bready);
    end
    step();
    checks++;
    if (out_cnt !== 3'd0) begin
      errors++; $display("FAIL id_cnt0: got %0d want 0", out_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_out_limit();
    do_reset();
    m_awvalid = 3'b001; s_awready = 1'b1;
    m_wvalid = 3'b001; m_wlast = 3'b001; s_wready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      checks++;
      if (s_awvalid !== 1'b1) begin
        errors++; $display("FAIL lim_grant%0d: got %b want 1", t, s_awvalid);
      end
      step();
      checks++;
      if (out_cnt !== 3'(t + 1)) begin
        errors++; $display("FAIL lim_cnt%0d: got %0d want %0d", t, out_cnt, t + 1);
      end
    end
    step();
    step();
    checks++;
    if ({s_awvalid, out_cnt} !== {1'b0, 3'd3}) begin
      errors++; $display("FAIL lim_block: got v=%b cnt=%0d want 0/3", s_awvalid, out_cnt);
    end
    s_bvalid = 1'b1; s_bid = 6'h00; m_bready = 3'b001;
    #1;
    checks++;
    if (m_bvalid !== 3'b001) begin
      errors++; $display("FAIL lim_bvalid: got %b want 001", m_bvalid);
    end
    step();
    s_bvalid = 1'b0;
    checks++;
    if ({s_awvalid, out_cnt} !== {1'b0, 3'd2}) begin
      errors++; $display("FAIL lim_after_b: got v=%b cnt=%0d want 0/2", s_awvalid, out_cnt);
    end
    step();
    checks++;
    if (s_awvalid !== 1'b1) begin
      errors++; $display("FAIL lim_regrant: got %b want 1", s_awvalid);
    end
    clear_inputs();
  endtask

  task automatic test_w_order();
    do_reset();
    s_awready = 1'b1;
    m_awvalid = 3'b100;
    step();
    m_awvalid = 3'b001;
    step();
    step();
    m_awvalid = 3'b000;
    step();
    m_wvalid = 3'b101; s_wready = 1'b1;
    m_wdata[0 +: 32] = 32'h0000_00A0;
    for (int b = 0; b < 3; b++) begin
      m_wdata[64 +: 32] = 32'h2000_0000 + 32'(b);
      m_wlast = (b == 2) ? 3'b101 : 3'b001;
      #1;
      checks++;
      if ({s_wvalid, s_wdata, s_wlast, m_wready} !== {1'b1, 32'h2000_0000 + 32'(b), (b == 2), 3'b100}) begin
        errors++; $display("FAIL word_m2_beat%0d: got v=%b d=%h l=%b rdy=%b want 1/%h/%0d/100",
                           b, s_wvalid, s_wdata, s_wlast, m_wready, 32'h2000_0000 + 32'(b), b == 2);
      end
      step();
    end
    m_wvalid = 3'b001; m_wlast = 3'b001;
    #1;
    checks++;
    if ({s_wvalid, s_wdata, s_wlast, m_wready} !== {1'b1, 32'h0000_00A0, 1'b1, 3'b001}) begin
      errors++; $display("FAIL word_m0: got v=%b d=%h l=%b rdy=%b want 1/000000a0/1/001",
                         s_wvalid, s_wdata, s_wlast, m_wready);
    end
    step();
    checks++;
    if ({s_wvalid, m_wready, out_cnt} !== {1'b0, 3'b000, 3'd2}) begin
      errors++; $display("FAIL word_empty: got v=%b rdy=%b cnt=%0d want 0/000/2", s_wvalid, m_wready, out_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_simul_aw_b();
    do_reset();
    m_awvalid = 3'b001; s_awready = 1'b1;
    m_wvalid = 3'b001; m_wlast = 3'b001; s_wready = 1'b1;
    step();
    step();
    step();
    checks++;
    if ({s_awvalid, out_cnt} !== {1'b1, 3'd1}) begin
      errors++; $display("FAIL sim_pre: got v=%b cnt=%0d want 1/1", s_awvalid, out_cnt);
    end
    m_awvalid = 3'b000;
    s_bvalid = 1'b1; s_bid = 6'h05; m_bready = 3'b001;
    #1;
    checks++;
    if ({m_bvalid, m_bid} !== {3'b001, 4'h5}) begin
      errors++; $display("FAIL sim_b_route: got bv=%b bid=%h want 001/5", m_bvalid, m_bid);
    end
    step();
    checks++;
    if ({s_awvalid, out_cnt} !== {1'b0, 3'd1}) begin
      errors++; $display("FAIL sim_cnt_hold: got v=%b cnt=%0d want 0/1", s_awvalid, out_cnt);
    end
    s_bid = 6'h30; m_bready = 3'b000;
    #1;
    checks++;
    if ({s_bready, m_bvalid} !== 4'b1000) begin
      errors++; $display("FAIL sim_discard: got bready=%b bv=%b want 1/000", s_bready, m_bvalid);
    end
    step();
    checks++;
    if (out_cnt !== 3'd0) begin
      errors++; $display("FAIL sim_cnt_dec: got %0d want 0", out_cnt);
    end
    step();
    checks++;
    if (out_cnt !== 3'd0) begin
      errors++; $display("FAIL sim_cnt_floor: got %0d want 0", out_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_awvalid = 3'b011; s_awready = 1'b1;
    step();
    step();
    step();
    step();
    s_awready = 1'b0; m_wvalid = 3'b111;
    step();
    checks++;
    if ({s_awvalid, s_wvalid, out_cnt} !== {1'b1, 1'b1, 3'd2}) begin
      errors++; $display("FAIL mid_pre: got aw=%b w=%b cnt=%0d want 1/1/2", s_awvalid, s_wvalid, out_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_awvalid, s_wvalid, out_cnt, m_awready, m_wready} !== 11'd0) begin
      errors++; $display("FAIL mid_reset: got aw=%b w=%b cnt=%0d awr=%b wr=%b want all 0",
                         s_awvalid, s_wvalid, out_cnt, m_awready, m_wready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_awvalid = 3'b111; s_awready = 1'b1;
    step();
    checks++;
    if ({s_awvalid, s_awid[5:4]} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL mid_first_grant: got v=%b idx=%0d want 1/0", s_awvalid, s_awid[5:4]);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_id_route();
    test_out_limit();
    test_w_order();
    test_simul_aw_b();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wr_slave_arbiter.md
WR_SLAVE_ARBITER -- requirements
Module: wr_slave_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, AW address width per master.
REQ-002 Parameter DATA_W, default 32, W data width per master.
REQ-003 Parameter MAX_OUT, default 3, maximum outstanding write transactions at the slave port (legal 1..7).
REQ-004 clk  in  1  single clock; all state is updated on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 m_awvalid / m_awready  in / out  3 / 3  per-master AW handshake; bit k belongs to master k.
REQ-007 m_awid / m_awaddr / m_awlen  in  12 / 3*ADDR_W / 24  per-master AW payload, packed with master k in slice k.
REQ-008 m_wvalid, m_wlast / m_wready  in / out  3 / 3  per-master W handshake.
REQ-009 m_wdata  in  3*DATA_W  per-master write data, packed.
REQ-010 m_bvalid / m_bready  out / in  3 / 3  per-master B handshake.
REQ-011 m_bid / m_bresp  out  4 / 2  shared B payload for all masters.
REQ-012 s_awvalid / s_awready  out / in  1 / 1  slave AW handshake.
REQ-013 s_awid / s_awaddr / s_awlen  out  6 / ADDR_W / 8  slave AW payload.
REQ-014 s_wvalid, s_wdata, s_wlast / s_wready  out / in  1, DATA_W, 1 / 1  slave W channel.
REQ-015 s_bvalid, s_bid, s_bresp / s_bready  in / out  1, 6, 2 / 1  slave B channel.
REQ-016 out_cnt  out  3  current outstanding transaction count.

Function
REQ-017 The AW FSM SHALL have two states: IDLE and GRANT.
REQ-018 IDLE->GRANT SHALL occur when any m_awvalid is set, out_cnt<MAX_OUT and the W-order FIFO is not full; the winner is registered on that edge.
REQ-019 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod 3 and takes the first requesting master.
REQ-020 In GRANT: s_awvalid=1, s_awid={grant_idx[1:0], m_awid slice}, s_awaddr/s_awlen from the winner slice, m_awready[grant_idx]=s_awready, other m_awready bits 0.
REQ-021 The grant SHALL be held in GRANT until s_awvalid&&s_awready; on that edge: push grant_idx into the W-order FIFO, out_cnt+1, last_grant<=grant_idx, return to IDLE.
REQ-022 Minimum AW throughput SHALL be one transaction per 2 cycles; no output valid depends combinationally on any input ready.
REQ-023 The W-order FIFO SHALL have depth MAX_OUT, 2-bit entries, and wrapping read/write pointers.
REQ-024 When the FIFO is empty: s_wvalid=0 and all m_wready=0.
REQ-025 When the FIFO is non-empty with head h: s_wvalid=m_wvalid[h], s_wdata/s_wlast from slice h, m_wready[h]=s_wready, other m_wready bits 0.
REQ-026 A W handshake with s_wlast=1 SHALL pop the FIFO; W from different transactions is never interleaved.
REQ-027 A push and a pop in the same cycle SHALL both take effect, and the FIFO count is unchanged.
REQ-028 B routing: idx=s_bid[5:4]; for idx 0..2, m_bvalid[idx]=s_bvalid, s_bready=m_bready[idx], m_bid=s_bid[3:0], m_bresp=s_bresp.
REQ-029 idx=3 SHALL be discarded: s_bready=1 and all m_bvalid=0.
REQ-030 Every s_bvalid&&s_bready handshake SHALL decrement out_cnt; a simultaneous AW handshake and B handshake SHALL leave out_cnt unchanged.
REQ-031 out_cnt SHALL saturate at 0 on a B handshake with out_cnt=0; no underflow wrap.
REQ-032 At out_cnt==MAX_OUT, IDLE SHALL remain IDLE until a B handshake lowers out_cnt.

Reset
REQ-033 rst_n low SHALL immediately force: FSM=IDLE, last_grant=2 (master 0 highest priority first), FIFO empty, out_cnt=0, all valid/ready outputs 0 except s_bready, which follows REQ-028/029.
REQ-034 Reset asserted mid-burst SHALL abandon all in-flight state; no handshake completes in the reset cycle.

Verification
REQ-035 All three m_awvalid held high, s_awready=1, B returned promptly -> grants in order 0,1,2,0; s_awid[5:4] follows that order.
REQ-036 Master1 AW with awid=4'hA, s_awready=1 -> s_awid=6'h1A; s_bid=6'h1A -> m_bvalid=3'b010, m_bid=4'hA.
REQ-037 Three AWs accepted, no B -> out_cnt=3 and a fourth m_awvalid gets no grant; one B handshake -> grant one cycle after out_cnt=2.
REQ-038 AWs from master2 then master0, both W streams valid -> slave sees all master2 beats through wlast, then master0 beats; m_wready[0]=0 until the pop.
REQ-039 AW handshake and B handshake in the same cycle at out_cnt=1 -> out_cnt stays 1; s_bid[5:4]=3 -> s_bready=1, no m_bvalid.
REQ-040 rst_n pulsed low while in GRANT with FIFO holding 2 entries -> s_awvalid=0, s_wvalid=0, out_cnt=0 immediately; after release, master0 wins first.
